exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_pkg.sv | 37 +++
 rtl/exc_ctrl_if.sv | 45 ++++
 rtl/exc_ctrl_prio.sv | 45 ++++
 rtl/exc_ctrl.sv | 114 +++++++++++
 tb/tb_exc_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: MIPS ExcCodes, CP0 register
// indices, FSM state encoding and the latched-exception record.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int CP0_BADVA  = 8;
    localparam int CP0_STATUS = 12;
    localparam int CP0_CAUSE  = 13;
    localparam int CP0_EPC    = 14;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_COMMIT   = 2'd1;
    localparam state_t ST_REDIRECT = 2'd2;

    typedef struct packed {
        logic       is_eret;
        logic [4:0] code;
        logic       bd;
    } exc_info_t;

    // Address and TLB faults are the only causes that also update BadVAddr.
    function automatic logic writes_badva(input logic [4:0] code);
        return (code == EXC_TLBL) || (code == EXC_TLBS) ||
               (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle between the MEM/commit stage, CP0 and fetch and the exception
// controller. The controller sits on the slave side.
interface exc_ctrl_if
    import exc_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic [7:0]       exc_req;
    logic             commit_valid;
    logic [WIDTH-1:0] commit_pc;
    logic             commit_bd;
    logic [WIDTH-1:0] commit_badva;
    logic             eret;
    logic [5:0]       hw_int;
    logic [WIDTH-1:0] status_in;
    logic [WIDTH-1:0] epc_in;
    logic             redirect_ready;

    logic [31:0]      cp0_we;
    logic [WIDTH-1:0] cp0_epc;
    logic [WIDTH-1:0] cp0_badva;
    logic [4:0]       cp0_exccode;
    logic             cp0_bd;
    logic             cp0_exl;
    logic             flush;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             busy;

    modport master (
        output exc_req, commit_valid, commit_pc, commit_bd, commit_badva,
               eret, hw_int, status_in, epc_in, redirect_ready,
        input  cp0_we, cp0_epc, cp0_badva, cp0_exccode, cp0_bd, cp0_exl,
               flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  exc_req, commit_valid, commit_pc, commit_bd, commit_badva,
               eret, hw_int, status_in, epc_in, redirect_ready,
        output cp0_we, cp0_epc, cp0_badva, cp0_exccode, cp0_bd, cp0_exl,
               flush, redirect_valid, redirect_pc, busy
    );

endinterface

// File: rtl/exc_ctrl_prio.sv
// Combinational priority encoder: interrupt, then exc_req[0..7], then ERET.
// hit is low when nothing is requested.
module exc_prio
    import exc_ctrl_pkg::*;
(
    input  logic       int_pending,
    input  logic [7:0] exc_req,
    input  logic [1:0] badva_lo,
    input  logic       eret,
    output logic       hit,
    output logic [4:0] code,
    output logic       is_eret
);

    always_comb begin
        hit     = 1'b1;
        code    = EXC_INT;
        is_eret = 1'b0;
        if (int_pending) begin
            code = EXC_INT;
        end else if (exc_req[0]) begin
            code = EXC_ADEL;
        end else if (exc_req[1]) begin
            code = EXC_TLBL;
        end else if (exc_req[2]) begin
            code = EXC_RI;
        end else if (exc_req[3]) begin
            code = EXC_OV;
        end else if (exc_req[4]) begin
            code = EXC_SYS;
        end else if (exc_req[5]) begin
            code = EXC_BP;
        end else if (exc_req[6]) begin
            // Data-load fault: a misaligned address is AdEL, an aligned one a TLB miss.
            code = (badva_lo != 2'b00) ? EXC_ADEL : EXC_TLBL;
        end else if (exc_req[7]) begin
            code = EXC_ADES;
        end else if (eret) begin
            is_eret = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt/ERET controller: IDLE -> COMMIT (one-cycle CP0 write and
// flush) -> REDIRECT (hold new fetch PC until accepted) -> IDLE.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
)(
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);

    state_t           state_q;
    exc_info_t        info_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] badva_q;
    logic [WIDTH-1:0] target_q;

    logic       int_pending;
    logic       prio_hit;
    logic [4:0] prio_code;
    logic       prio_eret;
    logic       trigger;
    logic       in_commit;
    logic       in_redirect;

    assign int_pending = bus.status_in[0] & ~bus.status_in[1] &
                         (|(bus.hw_int & bus.status_in[15:10]));

    exc_prio u_prio (
        .int_pending (int_pending),
        .exc_req     (bus.exc_req),
        .badva_lo    (bus.commit_badva[1:0]),
        .eret        (bus.eret),
        .hit         (prio_hit),
        .code        (prio_code),
        .is_eret     (prio_eret)
    );

    // Requests seen outside IDLE are dropped; the flush replays those instructions.
    assign trigger = (state_q == ST_IDLE) & bus.commit_valid & prio_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            info_q   <= '0;
            pc_q     <= '0;
            badva_q  <= '0;
            target_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        info_q.is_eret <= prio_eret;
                        info_q.code    <= prio_code;
                        info_q.bd      <= bus.commit_bd;
                        pc_q           <= bus.commit_pc;
                        badva_q        <= bus.commit_badva;
                        state_q        <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    target_q <= info_q.is_eret ? bus.epc_in : EXC_VECTOR;
                    state_q  <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst so a reset landing on COMMIT never issues a partial CP0 write.
    assign in_commit   = (state_q == ST_COMMIT) & ~rst;
    assign in_redirect = (state_q == ST_REDIRECT) & ~rst;
    assign bus.busy    = (state_q != ST_IDLE);

    always_comb begin
        bus.cp0_we         = '0;
        bus.cp0_epc        = '0;
        bus.cp0_badva      = '0;
        bus.cp0_exccode    = '0;
        bus.cp0_bd         = 1'b0;
        bus.cp0_exl        = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        if (in_commit) begin
            bus.flush = 1'b1;
            if (info_q.is_eret) begin
                bus.cp0_we[CP0_STATUS] = 1'b1;
            end else begin
                bus.cp0_we[CP0_EPC]    = 1'b1;
                bus.cp0_we[CP0_CAUSE]  = 1'b1;
                bus.cp0_we[CP0_STATUS] = 1'b1;
                bus.cp0_we[CP0_BADVA]  = writes_badva(info_q.code);
                bus.cp0_epc     = info_q.bd ? (pc_q - WIDTH'(4)) : pc_q;
                bus.cp0_badva   = badva_q;
                bus.cp0_exccode = info_q.code;
                bus.cp0_bd      = info_q.bd;
                bus.cp0_exl     = 1'b1;
            end
        end
        if (in_redirect) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = target_q;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: hand-computed expectations checked with
// immediate assertions, stepping the design one clock at a time.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    exc_ctrl_if #(.WIDTH(WIDTH)) bus ();

    exc_ctrl #(.WIDTH(WIDTH), .EXC_VECTOR(32'hBFC00380)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [7:0] req,
                                  input logic eret_i, input logic [31:0] pc,
                                  input logic bd, input logic [31:0] badva);
        bus.commit_valid = valid;
        bus.exc_req      = req;
        bus.eret         = eret_i;
        bus.commit_pc    = pc;
        bus.commit_bd    = bd;
        bus.commit_badva = badva;
    endtask

    task automatic clear_stimulus();
        apply_stimulus(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.redirect_ready = 1'b1;
        bus.status_in      = '0;
        bus.hw_int         = '0;
        bus.epc_in         = '0;
        clear_stimulus();
        tick();
        tick();
        check_output("rst_busy", 32'(bus.busy), 32'h0);
        check_output("rst_we", bus.cp0_we, 32'h0);
        check_output("rst_rv", 32'(bus.redirect_valid), 32'h0);
        check_output("rst_flush", 32'(bus.flush), 32'h0);
        rst = 1'b0;
        tick();

        // Overflow, not in a delay slot.
        apply_stimulus(1'b1, 8'h08, 1'b0, 32'h80001000, 1'b0, 32'h0);
        tick();
        clear_stimulus();
        check_output("ov_we", bus.cp0_we, 32'h00007000);
        check_output("ov_code", 32'(bus.cp0_exccode), 32'd12);
        check_output("ov_epc", bus.cp0_epc, 32'h80001000);
        check_output("ov_flush", 32'(bus.flush), 32'h1);
        check_output("ov_exl", 32'(bus.cp0_exl), 32'h1);
        check_output("ov_rv_commit", 32'(bus.redirect_valid), 32'h0);
        tick();
        check_output("ov_rv", 32'(bus.redirect_valid), 32'h1);
        check_output("ov_rpc", bus.redirect_pc, 32'hBFC00380);
        check_output("ov_we_redir", bus.cp0_we, 32'h0);
        check_output("ov_flush_redir", 32'(bus.flush), 32'h0);
        tick();
        check_output("ov_idle_busy", 32'(bus.busy), 32'h0);
        check_output("ov_idle_rv", 32'(bus.redirect_valid), 32'h0);

        // Fetch address error in a delay slot.
        apply_stimulus(1'b1, 8'h01, 1'b0, 32'h80002004, 1'b1, 32'h80002005);
        tick();
        clear_stimulus();
        check_output("adel_we", bus.cp0_we, 32'h00007100);
        check_output("adel_code", 32'(bus.cp0_exccode), 32'd4);
        check_output("adel_epc", bus.cp0_epc, 32'h80002000);
        check_output("adel_bd", 32'(bus.cp0_bd), 32'h1);
        check_output("adel_badva", bus.cp0_badva, 32'h80002005);
        tick();
        tick();

        // Interrupt beats Sys; with EXL set the interrupt is masked.
        bus.status_in = 32'h00000401;
        bus.hw_int    = 6'h01;
        apply_stimulus(1'b1, 8'h10, 1'b0, 32'h80004000, 1'b0, 32'h0);
        tick();
        clear_stimulus();
        check_output("int_code", 32'(bus.cp0_exccode), 32'd0);
        check_output("int_we", bus.cp0_we, 32'h00007000);
        tick();
        tick();
        bus.status_in = 32'h00000403;
        apply_stimulus(1'b1, 8'h10, 1'b0, 32'h80004000, 1'b0, 32'h0);
        tick();
        clear_stimulus();
        check_output("exl_sys_code", 32'(bus.cp0_exccode), 32'd8);
        tick();
        tick();

        // Masked interrupt line and invalid commit must not trigger.
        bus.status_in = 32'h00000401;
        bus.hw_int    = 6'h02;
        apply_stimulus(1'b1, 8'h00, 1'b0, 32'h80004000, 1'b0, 32'h0);
        tick();
        check_output("masked_int_busy", 32'(bus.busy), 32'h0);
        bus.status_in = '0;
        bus.hw_int    = '0;
        apply_stimulus(1'b0, 8'h08, 1'b0, 32'h80004000, 1'b0, 32'h0);
        tick();
        check_output("novalid_busy", 32'(bus.busy), 32'h0);
        clear_stimulus();

        // Data-load fault subtype, store error and exception priority.
        apply_stimulus(1'b1, 8'h40, 1'b0, 32'h80006000, 1'b0, 32'h80007000);
        tick();
        clear_stimulus();
        check_output("tlbl_code", 32'(bus.cp0_exccode), 32'd2);
        check_output("tlbl_we", bus.cp0_we, 32'h00007100);
        tick();
        tick();
        apply_stimulus(1'b1, 8'h40, 1'b0, 32'h80006000, 1'b0, 32'h80007002);
        tick();
        clear_stimulus();
        check_output("adel_data_code", 32'(bus.cp0_exccode), 32'd4);
        tick();
        tick();
        apply_stimulus(1'b1, 8'h80, 1'b0, 32'h80006000, 1'b0, 32'h80007001);
        tick();
        clear_stimulus();
        check_output("ades_code", 32'(bus.cp0_exccode), 32'd5);
        check_output("ades_we", bus.cp0_we, 32'h00007100);
        tick();
        tick();
        apply_stimulus(1'b1, 8'h0C, 1'b1, 32'h80006000, 1'b0, 32'h0);
        tick();
        clear_stimulus();
        check_output("ri_ov_code", 32'(bus.cp0_exccode), 32'd10);
        check_output("ri_ov_exl", 32'(bus.cp0_exl), 32'h1);
        tick();
        tick();

        // ERET returns to EPC sampled during COMMIT.
        bus.epc_in = 32'h80003000;
        apply_stimulus(1'b1, 8'h00, 1'b1, 32'h80008000, 1'b0, 32'h0);
        tick();
        clear_stimulus();
        check_output("eret_we", bus.cp0_we, 32'h00001000);
        check_output("eret_exl", 32'(bus.cp0_exl), 32'h0);
        check_output("eret_flush", 32'(bus.flush), 32'h1);
        tick();
        check_output("eret_rv", 32'(bus.redirect_valid), 32'h1);
        check_output("eret_rpc", bus.redirect_pc, 32'h80003000);
        bus.epc_in = '0;
        tick();

        // Fetch stalls the redirect; a new request in the window is ignored.
        bus.redirect_ready = 1'b0;
        apply_stimulus(1'b1, 8'h04, 1'b0, 32'h80005000, 1'b0, 32'h0);
        tick();
        clear_stimulus();
        check_output("stall_code", 32'(bus.cp0_exccode), 32'd10);
        tick();
        check_output("stall_rv0", 32'(bus.redirect_valid), 32'h1);
        apply_stimulus(1'b1, 8'h08, 1'b0, 32'h80009000, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("stall_rv", 32'(bus.redirect_valid), 32'h1);
            check_output("stall_rpc", bus.redirect_pc, 32'hBFC00380);
            check_output("stall_we", bus.cp0_we, 32'h0);
        end
        bus.redirect_ready = 1'b1;
        clear_stimulus();
        tick();
        check_output("stall_done_busy", 32'(bus.busy), 32'h0);
        tick();
        check_output("stall_ignored_busy", 32'(bus.busy), 32'h0);
        check_output("stall_ignored_we", bus.cp0_we, 32'h0);

        // Reset landing on COMMIT suppresses the CP0 write immediately.
        bus.redirect_ready = 1'b0;
        apply_stimulus(1'b1, 8'h08, 1'b0, 32'h80001000, 1'b0, 32'h0);
        tick();
        clear_stimulus();
        check_output("rstc_pre_we", bus.cp0_we, 32'h00007000);
        rst = 1'b1;
        #1;
        check_output("rstc_we", bus.cp0_we, 32'h0);
        check_output("rstc_flush", 32'(bus.flush), 32'h0);
        tick();
        rst = 1'b0;
        check_output("rstc_busy", 32'(bus.busy), 32'h0);

        // Reset during REDIRECT.
        apply_stimulus(1'b1, 8'h08, 1'b0, 32'h80001000, 1'b0, 32'h0);
        tick();
        clear_stimulus();
        tick();
        check_output("rstr_pre_rv", 32'(bus.redirect_valid), 32'h1);
        rst = 1'b1;
        tick();
        check_output("rstr_busy", 32'(bus.busy), 32'h0);
        check_output("rstr_rv", 32'(bus.redirect_valid), 32'h0);
        check_output("rstr_rpc", bus.redirect_pc, 32'h0);
        check_output("rstr_we", bus.cp0_we, 32'h0);
        check_output("rstr_flush", 32'(bus.flush), 32'h0);
        check_output("rstr_epc", bus.cp0_epc, 32'h0);
        rst = 1'b0;
        bus.redirect_ready = 1'b1;
        tick();
        check_output("rstr_after_busy", 32'(bus.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
